// File: rtl/tone_synth.sv
// Polyphonic square-wave tone generator: CHANNELS voices with note table,
// linear attack/release envelope, registered mix and a valid/ready sample source.
module tone_synth #(
    parameter int CHANNELS     = 3,
    parameter int CLK_HZ       = 50000000,
    parameter int DIV_W        = 17,
    parameter int SAMPLE_W     = 24,
    parameter int GAIN_W       = 8,
    parameter int ENV_STEP_DIV = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [CHANNELS-1:0]     gate,
    input  logic [3*CHANNELS-1:0]   note_sel,
    output logic [SAMPLE_W-1:0]     sample_data,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic [CHANNELS-1:0]     active_leds
);

    localparam logic [GAIN_W-1:0] LMAX     = {GAIN_W{1'b1}};
    localparam int                PRE_W    = (ENV_STEP_DIV > 1) ? $clog2(ENV_STEP_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(ENV_STEP_DIV - 1);

    typedef logic [7:0][DIV_W-1:0] reload_tbl_t;

    function automatic int note_hz(input int k);
        case (k)
            32'sd0:  return 32'sd262;
            32'sd1:  return 32'sd294;
            32'sd2:  return 32'sd330;
            32'sd3:  return 32'sd349;
            32'sd4:  return 32'sd392;
            32'sd5:  return 32'sd440;
            32'sd6:  return 32'sd494;
            32'sd7:  return 32'sd523;
            default: return 32'sd523;
        endcase
    endfunction

    function automatic longint reload_calc(input int k);
        return longint'(CLK_HZ) / (64'sd2 * longint'(note_hz(k))) - 64'sd1;
    endfunction

    function automatic reload_tbl_t build_reload_tbl();
        reload_tbl_t tbl;
        for (int k = 0; k < 8; k++) begin
            tbl[3'(k)] = DIV_W'(reload_calc(k));
        end
        return tbl;
    endfunction

    // Per-level amplitude chosen so CHANNELS voices at LMAX stay inside full scale.
    function automatic logic [SAMPLE_W-1:0] amp_unit_calc();
        logic [63:0] full_scale;
        logic [63:0] denom;
        full_scale = (64'd1 << (SAMPLE_W - 1)) - 64'd1;
        denom      = 64'(CHANNELS) * ((64'd1 << GAIN_W) - 64'd1);
        return SAMPLE_W'(full_scale / denom);
    endfunction

    localparam reload_tbl_t         RELOAD_TBL = build_reload_tbl();
    localparam logic [SAMPLE_W-1:0] AMP_UNIT   = amp_unit_calc();

    for (genvar k = 0; k < 8; k++) begin : g_reload_chk
        if (reload_calc(k) >= (64'sd1 <<< DIV_W)) begin : g_too_wide
            $error("tone_synth: note reload value does not fit in DIV_W bits");
        end
    end

    logic [PRE_W-1:0]    presc_r;
    logic                env_tick_s;
    logic [SAMPLE_W-1:0] psum_s [CHANNELS+1];
    logic [SAMPLE_W-1:0] mix_r;
    logic [CHANNELS-1:0] level_nz_s;

    assign env_tick_s = (presc_r == PRE_LAST);
    assign psum_s[0]  = '0;

    // Shared envelope prescaler; the tick cycle also wraps the counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            presc_r <= '0;
        end else if (env_tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_voice
        logic [2:0]          sel_s;
        logic                rise_s;
        logic                idle_s;
        logic                gate_q_r;
        logic                phase_r;
        logic [DIV_W-1:0]    cnt_r;
        logic [GAIN_W-1:0]   level_r;
        logic [SAMPLE_W-1:0] mag_s;
        logic [SAMPLE_W-1:0] term_s;

        assign sel_s  = note_sel[3*i +: 3];
        assign rise_s = gate[i] & ~gate_q_r;
        assign idle_s = ~gate[i] & (level_r == '0);

        // Gate history for edge detection and the saturating envelope level.
        always_ff @(posedge clock) begin
            if (!reset) begin
                gate_q_r <= 1'b0;
                level_r  <= '0;
            end else begin
                gate_q_r <= gate[i];
                if (env_tick_s) begin
                    if (gate[i]) begin
                        if (level_r != LMAX) begin
                            level_r <= level_r + 1'b1;
                        end
                    end else if (level_r != '0) begin
                        level_r <= level_r - 1'b1;
                    end
                end
            end
        end

        // Half-period divider; note_sel is only sampled at reload so halves never shorten.
        always_ff @(posedge clock) begin
            if (!reset) begin
                cnt_r   <= '0;
                phase_r <= 1'b0;
            end else if (rise_s) begin
                cnt_r   <= RELOAD_TBL[sel_s];
                phase_r <= 1'b0;
            end else if (idle_s) begin
                cnt_r   <= '0;
                phase_r <= 1'b0;
            end else if (cnt_r == '0) begin
                cnt_r   <= RELOAD_TBL[sel_s];
                phase_r <= ~phase_r;
            end else begin
                cnt_r   <= cnt_r - 1'b1;
            end
        end

        assign mag_s         = SAMPLE_W'(level_r) * AMP_UNIT;
        assign term_s        = phase_r ? mag_s : -mag_s;
        assign psum_s[i+1]   = psum_s[i] + term_s;
        assign level_nz_s[i] = (level_r != '0);
    end

    // Registered mix of all voice terms; headroom is guaranteed by AMP_UNIT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mix_r <= '0;
        end else begin
            mix_r <= psum_s[CHANNELS];
        end
    end

    // Stream source: load a new sample whenever the slot is empty or being consumed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else if (!sample_valid || sample_ready) begin
            sample_data  <= mix_r;
            sample_valid <= 1'b1;
        end else begin
            sample_data  <= sample_data;
            sample_valid <= sample_valid;
        end
    end

    // Voice activity indicators.
    always_ff @(posedge clock) begin
        if (!reset) begin
            active_leds <= '0;
        end else begin
            active_leds <= level_nz_s;
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// Directed self-checking bench for tone_synth at CLK_HZ=8800, GAIN_W=2, ENV_STEP_DIV=2.
module tb_tone_synth;

    localparam int A1 = 932067;
    localparam int A2 = 1864134;
    localparam int A3 = 2796201;
    localparam int A9 = 8388603;

    logic        clock;
    logic        reset;
    logic [2:0]  gate;
    logic [8:0]  note_sel;
    logic [23:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [2:0]  active_leds;

    int checks    = 0;
    int errors    = 0;
    int pidx      = 0;
    int rel_edges = 0;

    tone_synth #(
        .CHANNELS    (3),
        .CLK_HZ      (8800),
        .DIV_W       (17),
        .SAMPLE_W    (24),
        .GAIN_W      (2),
        .ENV_STEP_DIV(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .gate        (gate),
        .note_sel    (note_sel),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .active_leds (active_leds)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edges since reset release; envelope ticks land on even counts.
    always @(posedge clock) rel_edges <= reset ? rel_edges + 1 : 0;

    task automatic step();
        @(negedge clock);
        pidx++;
    endtask

    task automatic step_to(input int target);
        while (pidx < target) step();
    endtask

    // Park on a negedge whose following posedge is not an envelope tick.
    task automatic align_non_tick();
        step();
        while ((rel_edges % 2) != 0) step();
    endtask

    task automatic test_reset();
        reset = 1'b0; gate = 3'b000; note_sel = 9'd0; sample_ready = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
        checks++;
        if (sample_data !== 24'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", sample_data); end
        checks++;
        if (active_leds !== 3'b000) begin errors++; $display("FAIL reset_leds: got %b expected 000", active_leds); end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (sample_valid !== 1'b1) begin errors++; $display("FAIL idle_valid_rise: got %b expected 1", sample_valid); end
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            checks++;
            if (sample_data !== 24'd0 || active_leds !== 3'b000) begin
                errors++;
                $display("FAIL idle_quiet: data %0d leds %b expected 0 000", sample_data, active_leds);
            end
        end
    endtask

    task automatic test_tone_period();
        align_non_tick();
        note_sel = 9'd5; gate = 3'b001; pidx = -1;
        step_to(2);
        checks++;
        if ($signed(sample_data) !== 0) begin errors++; $display("FAIL tone_k0: got %0d expected 0", $signed(sample_data)); end
        step_to(3);
        checks++;
        if ($signed(sample_data) !== -A1) begin errors++; $display("FAIL tone_k1: got %0d expected %0d", $signed(sample_data), -A1); end
        step_to(5);
        checks++;
        if ($signed(sample_data) !== -A2) begin errors++; $display("FAIL tone_k3: got %0d expected %0d", $signed(sample_data), -A2); end
        step_to(7);
        checks++;
        if ($signed(sample_data) !== -A3) begin errors++; $display("FAIL tone_k5: got %0d expected %0d", $signed(sample_data), -A3); end
        checks++;
        if (active_leds !== 3'b001) begin errors++; $display("FAIL tone_leds: got %b expected 001", active_leds); end
        step_to(11);
        checks++;
        if ($signed(sample_data) !== -A3) begin errors++; $display("FAIL tone_k9: got %0d expected %0d", $signed(sample_data), -A3); end
        step_to(12);
        checks++;
        if ($signed(sample_data) !== A3) begin errors++; $display("FAIL tone_k10: got %0d expected %0d", $signed(sample_data), A3); end
        step_to(21);
        checks++;
        if ($signed(sample_data) !== A3) begin errors++; $display("FAIL tone_k19: got %0d expected %0d", $signed(sample_data), A3); end
        step_to(22);
        checks++;
        if ($signed(sample_data) !== -A3) begin errors++; $display("FAIL tone_k20: got %0d expected %0d", $signed(sample_data), -A3); end
        step_to(32);
        checks++;
        if ($signed(sample_data) !== A3) begin errors++; $display("FAIL tone_k30: got %0d expected %0d", $signed(sample_data), A3); end
    endtask

    task automatic test_note_change();
        step_to(34);
        note_sel = 9'd0;
        step_to(41);
        checks++;
        if ($signed(sample_data) !== A3) begin errors++; $display("FAIL chg_k39: got %0d expected %0d", $signed(sample_data), A3); end
        step_to(42);
        checks++;
        if ($signed(sample_data) !== -A3) begin errors++; $display("FAIL chg_k40: got %0d expected %0d", $signed(sample_data), -A3); end
        step_to(57);
        checks++;
        if ($signed(sample_data) !== -A3) begin errors++; $display("FAIL chg_k55: got %0d expected %0d", $signed(sample_data), -A3); end
        step_to(58);
        checks++;
        if ($signed(sample_data) !== A3) begin errors++; $display("FAIL chg_k56: got %0d expected %0d", $signed(sample_data), A3); end
        step_to(73);
        checks++;
        if ($signed(sample_data) !== A3) begin errors++; $display("FAIL chg_k71: got %0d expected %0d", $signed(sample_data), A3); end
        step_to(74);
        checks++;
        if ($signed(sample_data) !== -A3) begin errors++; $display("FAIL chg_k72: got %0d expected %0d", $signed(sample_data), -A3); end
    endtask

    task automatic test_release();
        step_to(80);
        gate = 3'b000;
        step_to(82);
        checks++;
        if ($signed(sample_data) !== -A3) begin errors++; $display("FAIL rel_k80: got %0d expected %0d", $signed(sample_data), -A3); end
        step_to(83);
        checks++;
        if ($signed(sample_data) !== -A2) begin errors++; $display("FAIL rel_k81: got %0d expected %0d", $signed(sample_data), -A2); end
        step_to(85);
        checks++;
        if ($signed(sample_data) !== -A1) begin errors++; $display("FAIL rel_k83: got %0d expected %0d", $signed(sample_data), -A1); end
        checks++;
        if (active_leds !== 3'b001) begin errors++; $display("FAIL rel_leds_on: got %b expected 001", active_leds); end
        step_to(86);
        checks++;
        if (active_leds !== 3'b000) begin errors++; $display("FAIL rel_leds_off: got %b expected 000", active_leds); end
        step_to(87);
        checks++;
        if ($signed(sample_data) !== 0) begin errors++; $display("FAIL rel_k85: got %0d expected 0", $signed(sample_data)); end
        step_to(102);
        checks++;
        if ($signed(sample_data) !== 0 || active_leds !== 3'b000) begin
            errors++; $display("FAIL rel_silent: data %0d leds %b expected 0 000", $signed(sample_data), active_leds);
        end
    endtask

    task automatic test_polyphony();
        align_non_tick();
        note_sel = {3'd5, 3'd5, 3'd5}; gate = 3'b111; pidx = -1;
        step_to(3);
        checks++;
        if ($signed(sample_data) !== -A3) begin errors++; $display("FAIL poly_k1: got %0d expected %0d", $signed(sample_data), -A3); end
        step_to(7);
        checks++;
        if ($signed(sample_data) !== -A9) begin errors++; $display("FAIL poly_k5: got %0d expected %0d", $signed(sample_data), -A9); end
        checks++;
        if (active_leds !== 3'b111) begin errors++; $display("FAIL poly_leds: got %b expected 111", active_leds); end
        step_to(12);
        checks++;
        if ($signed(sample_data) !== A9) begin errors++; $display("FAIL poly_k10: got %0d expected %0d", $signed(sample_data), A9); end
        step_to(22);
        checks++;
        if ($signed(sample_data) !== -A9) begin errors++; $display("FAIL poly_k20: got %0d expected %0d", $signed(sample_data), -A9); end
        step_to(23);
        gate = 3'b101;
        step_to(24);
        gate = 3'b111;
        step_to(27);
        checks++;
        if ($signed(sample_data) !== -A9) begin errors++; $display("FAIL poly_k25: got %0d expected %0d", $signed(sample_data), -A9); end
        step_to(32);
        checks++;
        if ($signed(sample_data) !== A3) begin errors++; $display("FAIL poly_k30: got %0d expected %0d", $signed(sample_data), A3); end
        step_to(38);
        checks++;
        if ($signed(sample_data) !== A9) begin errors++; $display("FAIL poly_k36: got %0d expected %0d", $signed(sample_data), A9); end
        step_to(42);
        checks++;
        if ($signed(sample_data) !== -A3) begin errors++; $display("FAIL poly_k40: got %0d expected %0d", $signed(sample_data), -A3); end
        step_to(48);
        checks++;
        if ($signed(sample_data) !== -A9) begin errors++; $display("FAIL poly_k46: got %0d expected %0d", $signed(sample_data), -A9); end
    endtask

    task automatic test_backpressure();
        step_to(50);
        checks++;
        if ($signed(sample_data) !== -A9) begin errors++; $display("FAIL bp_pre: got %0d expected %0d", $signed(sample_data), -A9); end
        sample_ready = 1'b0;
        step_to(51);
        checks++;
        if ($signed(sample_data) !== -A9 || sample_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold_start: data %0d valid %b expected %0d 1", $signed(sample_data), sample_valid, -A9);
        end
        step_to(65);
        checks++;
        if ($signed(sample_data) !== -A9) begin errors++; $display("FAIL bp_hold_mid: got %0d expected %0d", $signed(sample_data), -A9); end
        step_to(80);
        checks++;
        if ($signed(sample_data) !== -A9 || sample_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold_end: data %0d valid %b expected %0d 1", $signed(sample_data), sample_valid, -A9);
        end
        sample_ready = 1'b1;
        step_to(81);
        checks++;
        if ($signed(sample_data) !== A9) begin errors++; $display("FAIL bp_resume: got %0d expected %0d", $signed(sample_data), A9); end
    endtask

    task automatic test_reset_mid_note();
        step_to(90);
        reset = 1'b0;
        step_to(91);
        checks++;
        if (sample_data !== 24'd0 || sample_valid !== 1'b0 || active_leds !== 3'b000) begin
            errors++; $display("FAIL midrst_clear: data %0d valid %b leds %b expected 0 0 000", sample_data, sample_valid, active_leds);
        end
        reset = 1'b1;
        step_to(92);
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== 24'd0) begin
            errors++; $display("FAIL midrst_first: valid %b data %0d expected 1 0", sample_valid, sample_data);
        end
        step_to(93);
        checks++;
        if (active_leds !== 3'b000) begin errors++; $display("FAIL midrst_leds_off: got %b expected 000", active_leds); end
        step_to(94);
        checks++;
        if (active_leds !== 3'b111 || $signed(sample_data) !== 0) begin
            errors++; $display("FAIL midrst_attack0: leds %b data %0d expected 111 0", active_leds, $signed(sample_data));
        end
        step_to(95);
        checks++;
        if ($signed(sample_data) !== -A3) begin errors++; $display("FAIL midrst_attack1: got %0d expected %0d", $signed(sample_data), -A3); end
    endtask

    initial begin
        test_reset();
        test_tone_period();
        test_note_change();
        test_release();
        test_polyphony();
        test_backpressure();
        test_reset_mid_note();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
